uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one UART transmitter (range 2..8).
REQ-002 Parameter MAX_BURST, default 4, maximum consecutive bytes one requester sends before the grant rotates (range 1..16).
REQ-003 Parameter START_TIMEOUT, default 16, clk_50m cycles to wait for tx_busy to rise after a write (range 2..255).
REQ-004 clk_50m  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req  input  NUM_REQ  per-requester byte-pending flag, level, held until ack.
REQ-007 req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i], stable while req[i] is high.
REQ-008 ack  output  NUM_REQ  one-cycle pulse: byte of requester i handed to the transmitter.
REQ-009 tx_wr_en  output  1  one-cycle write strobe to the transmitter.
REQ-010 tx_din  output  8  byte presented with tx_wr_en.
REQ-011 tx_busy  input  1  transmitter frame in progress.
REQ-012 grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-013 timeout_err  output  1  one-cycle pulse: tx_busy did not rise within START_TIMEOUT.

Function
REQ-014 FSM states IDLE, ISSUE, WAIT_START, WAIT_DONE; reset state IDLE.
REQ-015 IDLE: when tx_busy is low and any req bit is set, select a winner, register grant_id, go to ISSUE next cycle.
REQ-016 Winner selection is round-robin: search starts at (last grant_id + 1) mod NUM_REQ, wrapping.
REQ-017 Burst rule: if the previous winner still has req high and its burst count < MAX_BURST, it wins again regardless of round-robin order.
REQ-018 Burst count resets to 1 when a different requester wins, increments on each repeat win, saturates at MAX_BURST.
REQ-019 ISSUE lasts exactly one cycle: tx_wr_en=1, tx_din=req_data[grant_id], ack[grant_id]=1, all in the same cycle; next state WAIT_START.
REQ-020 WAIT_START: go to WAIT_DONE on the first cycle tx_busy is high; the timeout counter increments each cycle otherwise.
REQ-021 On the timeout counter reaching START_TIMEOUT, pulse timeout_err for one cycle and return to IDLE; the byte counts as consumed (no re-issue).
REQ-022 WAIT_DONE: return to IDLE on the first cycle tx_busy is low.
REQ-023 Minimum issue-to-issue spacing is therefore 4 cycles plus the frame time; at most one byte in flight.
REQ-024 A requester dropping req before its ISSUE cycle is not acked; if no req remains at ISSUE, emit no strobe and return to IDLE.
REQ-025 Simultaneous requests: exactly one ack bit set per ISSUE; ack is never set outside ISSUE.
REQ-026 tx_din is 0 whenever tx_wr_en is 0.

Reset
REQ-027 On rst: state IDLE, ack=0, tx_wr_en=0, tx_din=0, timeout_err=0, grant_id=NUM_REQ-1 (so requester 0 has first priority), burst count 0, timeout counter 0.
REQ-028 rst asserted mid-frame abandons the transaction with no ack or strobe; after release the block waits in IDLE for tx_busy low.

Structure
REQ-029 State encoding and default parameter constants (NUM_REQ, MAX_BURST, START_TIMEOUT) live in the shared package uart_pkg.
REQ-030 Round-robin selection is one combinational sub-module rr_pick (inputs req, last index; outputs valid, index).
REQ-031 All outputs are driven from registers; there is no combinational path from req or tx_busy to any output.

Verification
REQ-032 Single request: req=4'b0100, data byte 0xA5, tx_busy pulsed high for 10 cycles -> one ack[2], tx_din=0xA5, grant_id=2, timeout_err never set.
REQ-033 Fairness: all four req held, MAX_BURST=1 -> acks in order 0,1,2,3,0 each separated by a frame.
REQ-034 Burst: req[1] held, req[3] held, MAX_BURST=4 -> four acks on 1, then one on 3, then 1 again.
REQ-035 Timeout: req[0] high, tx_busy held low -> ISSUE, timeout_err pulses exactly START_TIMEOUT cycles later, FSM back in IDLE.
REQ-036 Reset mid-frame: rst asserted during WAIT_DONE -> all outputs 0 immediately, next grant after release goes to requester 0.
REQ-037 Withdrawn request: req[2] dropped in the cycle it wins -> no ack, no tx_wr_en, FSM returns to IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and default constants for the UART TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default requester count, burst length and busy-rise timeout.
    localparam int C_NUM_REQ       = 4;
    localparam int C_MAX_BURST     = 4;
    localparam int C_START_TIMEOUT = 16;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ISSUE      = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches req starting one
//               position after 'last', wrapping, and returns the first hit.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_pkg::*;
#(
    parameter  int NUM_REQ = C_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    // One spare bit so last + NUM_REQ cannot overflow before the wrap.
    logic [IDX_W:0] w_sum;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        valid = 1'b0;
        index = '0;
        w_sum = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_sum = (IDX_W+1)'(last) + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
            end
            if (req[w_sum[IDX_W-1:0]]) begin
                valid = 1'b1;
                index = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmitter between NUM_REQ byte requesters
//               using round-robin arbitration with bounded bursts. One byte
//               in flight at a time; all outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ       = C_NUM_REQ,
    parameter  int MAX_BURST     = C_MAX_BURST,
    parameter  int START_TIMEOUT = C_START_TIMEOUT,
    localparam int IDX_W         = $clog2(NUM_REQ)
) (
    input  logic                   clk_50m,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   tx_wr_en,
    output logic [7:0]             tx_din,
    input  logic                   tx_busy,
    output logic [IDX_W-1:0]       grant_id,
    output logic                   timeout_err
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [IDX_W-1:0]     r_grant;
    logic [IDX_W-1:0]     w_grant_nxt;
    logic [4:0]           r_burst;
    logic [4:0]           w_burst_nxt;
    logic [7:0]           r_tmo_cnt;
    logic [7:0]           w_tmo_cnt_nxt;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   w_ack_nxt;
    logic                 r_wr_en;
    logic                 w_wr_en_nxt;
    logic [7:0]           r_din;
    logic [7:0]           w_din_nxt;
    logic                 r_tmo_err;
    logic                 w_tmo_err_nxt;

    logic                 w_rr_valid;
    logic [IDX_W-1:0]     w_rr_idx;
    logic                 w_sticky;
    logic [IDX_W-1:0]     w_winner;
    logic [7:0]           w_bytes [NUM_REQ];

    // Split the flat data bus into per-requester bytes.
    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_bytes[i] = req_data[8*i +: 8];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req   (req),
        .last  (r_grant),
        .valid (w_rr_valid),
        .index (w_rr_idx)
    );

    // Previous winner keeps the grant while it still requests and has burst
    // budget left; a zero count means nobody has won since reset.
    assign w_sticky = (r_burst != 5'd0) && req[r_grant] && (r_burst < 5'(MAX_BURST));
    assign w_winner = w_sticky ? r_grant : w_rr_idx;

    // Next-state and next-output decode; outputs are pulses unless set here.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_burst_nxt   = r_burst;
        w_tmo_cnt_nxt = r_tmo_cnt;
        w_ack_nxt     = '0;
        w_wr_en_nxt   = 1'b0;
        w_din_nxt     = 8'h00;
        w_tmo_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!tx_busy && w_rr_valid) begin
                    w_state_nxt = ST_ISSUE;
                    w_grant_nxt = w_winner;
                    if (w_winner == r_grant) begin
                        if (r_burst < 5'(MAX_BURST)) begin
                            w_burst_nxt = r_burst + 5'd1;
                        end
                    end else begin
                        w_burst_nxt = 5'd1;
                    end
                end
            end
            ST_ISSUE: begin
                w_tmo_cnt_nxt = 8'd0;
                // A winner that withdrew before now gets nothing.
                if (req[r_grant]) begin
                    w_state_nxt          = ST_WAIT_START;
                    w_wr_en_nxt          = 1'b1;
                    w_din_nxt            = w_bytes[r_grant];
                    w_ack_nxt[r_grant]   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_START: begin
                if (tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
                    // Byte is treated as consumed; no retry after a timeout.
                    if (r_tmo_cnt == 8'(START_TIMEOUT - 1)) begin
                        w_tmo_err_nxt = 1'b1;
                        w_state_nxt   = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; grant resets to the last index so
    // requester 0 is searched first.
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= IDX_W'(NUM_REQ - 1);
            r_burst   <= 5'd0;
            r_tmo_cnt <= 8'd0;
            r_ack     <= '0;
            r_wr_en   <= 1'b0;
            r_din     <= 8'h00;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_burst   <= w_burst_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
            r_ack     <= w_ack_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_din     <= w_din_nxt;
            r_tmo_err <= w_tmo_err_nxt;
        end
    end

    assign ack         = r_ack;
    assign tx_wr_en    = r_wr_en;
    assign tx_din      = r_din;
    assign grant_id    = r_grant;
    assign timeout_err = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter. Instance a
//               uses default parameters, instance b uses MAX_BURST = 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int FRAME = 10;

    logic        clk_50m;
    logic        rst;

    logic [3:0]  req_a,  req_b;
    logic [31:0] data_a, data_b;
    logic [3:0]  ack_a,  ack_b;
    logic        wr_a,   wr_b;
    logic [7:0]  din_a,  din_b;
    logic        busy_a, busy_b;
    logic [1:0]  gid_a,  gid_b;
    logic        err_a,  err_b;

    // Bench bookkeeping.
    int checks = 0;
    int passes = 0;
    int cycle  = 0;
    logic [3:0] hold_a, hold_b;
    logic       tx_en_a, tx_en_b;
    int busy_left_a, busy_left_b;
    int log_a[$], log_b[$], cyc_b[$];
    int dlog_a[$];
    int wr_cnt_a, err_cnt_a, proto_a, proto_b;

    uart_tx_arbiter dut_a (
        .clk_50m     (clk_50m),
        .rst         (rst),
        .req         (req_a),
        .req_data    (data_a),
        .ack         (ack_a),
        .tx_wr_en    (wr_a),
        .tx_din      (din_a),
        .tx_busy     (busy_a),
        .grant_id    (gid_a),
        .timeout_err (err_a)
    );

    uart_tx_arbiter #(
        .MAX_BURST (1)
    ) dut_b (
        .clk_50m     (clk_50m),
        .rst         (rst),
        .req         (req_b),
        .req_data    (data_b),
        .ack         (ack_b),
        .tx_wr_en    (wr_b),
        .tx_din      (din_b),
        .tx_busy     (busy_b),
        .grant_id    (gid_b),
        .timeout_err (err_b)
    );

    initial clk_50m = 1'b0;
    always #10 clk_50m = ~clk_50m;

    // Safety net in case a bounded loop is mis-sized.
    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic int oh_idx(input logic [3:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // One clock: sample at the falling edge, then play requesters/transmitters.
    task automatic step();
        int i;
        @(negedge clk_50m);
        cycle++;
        if (wr_a) wr_cnt_a++;
        if (err_a) err_cnt_a++;
        if (!wr_a && (din_a !== 8'h00 || ack_a !== 4'b0)) proto_a++;
        if (ack_a !== 4'b0) begin
            if (!$onehot(ack_a)) proto_a++;
            else begin
                i = oh_idx(ack_a);
                if (din_a !== data_a[8*i +: 8]) proto_a++;
                log_a.push_back(i);
                dlog_a.push_back(int'(din_a));
                if (!hold_a[i]) req_a[i] = 1'b0;
            end
        end
        if (busy_left_a > 0) begin
            busy_left_a--;
            if (busy_left_a == 0) busy_a = 1'b0;
        end else if (tx_en_a && wr_a) begin
            busy_a = 1'b1;
            busy_left_a = FRAME;
        end
        if (!wr_b && (din_b !== 8'h00 || ack_b !== 4'b0)) proto_b++;
        if (ack_b !== 4'b0) begin
            if (!$onehot(ack_b)) proto_b++;
            else begin
                i = oh_idx(ack_b);
                if (din_b !== data_b[8*i +: 8]) proto_b++;
                log_b.push_back(i);
                cyc_b.push_back(cycle);
                if (!hold_b[i]) req_b[i] = 1'b0;
            end
        end
        if (busy_left_b > 0) begin
            busy_left_b--;
            if (busy_left_b == 0) busy_b = 1'b0;
        end else if (tx_en_b && wr_b) begin
            busy_b = 1'b1;
            busy_left_b = FRAME;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic wait_log_a(input int n, input int budget, input string tag);
        int k = 0;
        while (log_a.size() < n && k < budget) begin step(); k++; end
        check(tag, 32'(log_a.size() >= n), 32'd1);
    endtask

    task automatic wait_log_b(input int n, input int budget, input string tag);
        int k = 0;
        while (log_b.size() < n && k < budget) begin step(); k++; end
        check(tag, 32'(log_b.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_a = 4'b0; req_b = 4'b0;
        hold_a = 4'b0; hold_b = 4'b0;
        step(); step();
        rst = 1'b0;
        log_a.delete(); dlog_a.delete(); log_b.delete(); cyc_b.delete();
        wr_cnt_a = 0; err_cnt_a = 0;
    endtask

    initial begin
        int exp_burst[6];
        int exp_fair[5];
        int t0, t1, k;
        exp_burst = '{1, 1, 1, 1, 3, 1};
        exp_fair  = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        req_a = 4'b0; req_b = 4'b0;
        data_a = {8'h3C, 8'hA5, 8'h5A, 8'h11};
        data_b = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        busy_a = 1'b0; busy_b = 1'b0;
        busy_left_a = 0; busy_left_b = 0;
        tx_en_a = 1'b1; tx_en_b = 1'b1;
        hold_a = 4'b0; hold_b = 4'b0;
        wr_cnt_a = 0; err_cnt_a = 0; proto_a = 0; proto_b = 0;

        // Reset values.
        step(); step();
        check("rst_ack",   32'(ack_a), 32'h0);
        check("rst_wr",    32'(wr_a),  32'h0);
        check("rst_din",   32'(din_a), 32'h0);
        check("rst_err",   32'(err_a), 32'h0);
        check("rst_gid_a", 32'(gid_a), 32'h3);
        check("rst_gid_b", 32'(gid_b), 32'h3);
        rst = 1'b0;
        step();

        // Single request from requester 2.
        req_a = 4'b0100;
        wait_log_a(1, 40, "single_wait");
        run(30);
        check("single_cnt",  32'(log_a.size()), 32'd1);
        if (log_a.size() > 0) begin
            check("single_idx", 32'(log_a[0]),  32'd2);
            check("single_din", 32'(dlog_a[0]), 32'hA5);
        end
        check("single_gid",  32'(gid_a),     32'd2);
        check("single_wr",   32'(wr_cnt_a),  32'd1);
        check("single_err",  32'(err_cnt_a), 32'd0);

        // Fairness with MAX_BURST = 1, all four held.
        do_reset();
        hold_b = 4'b1111; req_b = 4'b1111;
        wait_log_b(5, 200, "fair_wait");
        hold_b = 4'b0; req_b = 4'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < log_b.size()) check($sformatf("fair_%0d", i), 32'(log_b[i]), 32'(exp_fair[i]));
        end
        for (int i = 1; i < 5; i++) begin
            if (i < cyc_b.size()) check($sformatf("fair_gap_%0d", i), 32'((cyc_b[i] - cyc_b[i-1]) >= FRAME + 3), 32'd1);
        end
        run(30);

        // Burst: 1 held, 3 requests one byte; MAX_BURST = 4.
        do_reset();
        hold_a = 4'b0010; req_a = 4'b1010;
        wait_log_a(6, 200, "burst_wait");
        hold_a = 4'b0; req_a = 4'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < log_a.size()) check($sformatf("burst_%0d", i), 32'(log_a[i]), 32'(exp_burst[i]));
        end
        run(30);

        // Timeout: transmitter never goes busy.
        do_reset();
        tx_en_a = 1'b0;
        req_a = 4'b0001;
        k = 0;
        while (wr_cnt_a == 0 && k < 20) begin step(); k++; end
        t0 = cycle;
        check("to_issue", 32'(wr_cnt_a), 32'd1);
        k = 0;
        while (err_cnt_a == 0 && k < 40) begin step(); k++; end
        t1 = cycle;
        check("to_delay", 32'(t1 - t0), 32'd16);
        check("to_state", 32'(dut_a.r_state), 32'(ST_IDLE));
        step();
        check("to_pulse", 32'(err_a), 32'd0);
        run(20);
        check("to_noreissue", 32'(wr_cnt_a),  32'd1);
        check("to_errcnt",    32'(err_cnt_a), 32'd1);
        tx_en_a = 1'b1;

        // Reset during WAIT_DONE.
        do_reset();
        req_a = 4'b0100;
        wait_log_a(1, 40, "rmid_wait");
        run(3);
        check("rmid_pre_state", 32'(dut_a.r_state), 32'(ST_WAIT_DONE));
        req_a = 4'b1101;
        rst = 1'b1;
        #1;
        check("rmid_ack",   32'(ack_a), 32'h0);
        check("rmid_wr",    32'(wr_a),  32'h0);
        check("rmid_din",   32'(din_a), 32'h0);
        check("rmid_err",   32'(err_a), 32'h0);
        check("rmid_gid",   32'(gid_a), 32'h3);
        check("rmid_state", 32'(dut_a.r_state), 32'(ST_IDLE));
        step(); step();
        rst = 1'b0;
        log_a.delete(); dlog_a.delete();
        wait_log_a(1, 60, "rmid_next_wait");
        if (log_a.size() > 0) check("rmid_next", 32'(log_a[0]), 32'd0);
        req_a = 4'b0;
        run(40);

        // Withdrawn request: drop req[2] right after it wins.
        do_reset();
        req_a = 4'b0100;
        step();
        check("wd_issue_state", 32'(dut_a.r_state), 32'(ST_ISSUE));
        req_a = 4'b0;
        run(10);
        check("wd_noack",  32'(log_a.size()),    32'd0);
        check("wd_nowr",   32'(wr_cnt_a),        32'd0);
        check("wd_state",  32'(dut_a.r_state),   32'(ST_IDLE));
        check("wd_gid",    32'(gid_a),           32'd2);

        // Protocol invariants gathered over the whole run.
        check("proto_a", 32'(proto_a), 32'd0);
        check("proto_b", 32'(proto_b), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
